// File: rtl/bus_arb_mux_pkg.sv
// Shared defaults, arbiter state encoding and one-hot decode helper for bus_arb_mux.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bus_arb_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_N     = 32;
    // Widest channel count the decode helper has to cover.
    localparam int MAX_N     = 64;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } arb_state_t;

    // Index of the set bit in a one-hot vector; zero when no bit is set.
    function automatic logic [5:0] onehot_to_idx(input logic [MAX_N-1:0] vec);
        logic [5:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (vec[i]) begin
                idx = idx | 6'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/bus_arb_mux_rr_arbiter.sv
// Round-robin priority search: first set request at or after ptr, wrapping mod N.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the winner is taken.
module rr_arbiter #(
    parameter int N    = 32,
    parameter int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req_masked,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic            found
);

    // Scan from ptr upward, wrapping, and keep only the first requester seen.
    always_comb begin
        int idx;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req_masked[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arb_mux.sv
// Registered N-channel bus mux: round-robin arbiter with per-channel lock picks the word.
// Latency: one cycle from request to out_valid/out_data.
// Backpressure: output register holds bit-stable while out_valid && !out_ready; no grant then.
module bus_arb_mux
    import bus_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N,
    parameter int SELW  = $clog2(N)
) (
    input  logic               clock,
    input  logic               clear,
    input  logic [N-1:0]       req,
    input  logic [N-1:0]       lock,
    input  logic [N*WIDTH-1:0] data_in,
    output logic [N-1:0]       grant,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel,
    output logic               locked
);

    arb_state_t      state;
    logic [SELW-1:0] ptr;
    logic            ld;
    logic [N-1:0]    eligible;
    logic [N-1:0]    req_masked;
    logic [N-1:0]    win;
    logic            found;
    logic [SELW-1:0] win_idx;
    logic [SELW-1:0] ptr_next;

    // The register may load when empty or when the consumer takes the current word.
    assign ld = !out_valid || out_ready;

    // While locked only the owner of the held word may win; otherwise everyone competes.
    always_comb begin
        eligible   = (state == ST_LOCKED) ? (N'(1) << out_sel) : '1;
        req_masked = req & eligible;
    end

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_rr_arbiter (
        .req_masked (req_masked),
        .ptr        (ptr),
        .gnt        (win),
        .found      (found)
    );

    // Winner index and the wrapped successor that becomes the next search start.
    always_comb begin
        win_idx  = SELW'(onehot_to_idx(MAX_N'(win)));
        ptr_next = (int'(win_idx) == N - 1) ? '0 : win_idx + SELW'(1);
    end

    // Grant only reflects a capture that really happens at this edge.
    assign grant = (ld && found && !clear) ? win : '0;

    // Lock FSM, search pointer and output register; outputs are all registered here.
    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= ST_UNLOCKED;
            locked    <= 1'b0;
            ptr       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (ld) begin
            if (found) begin
                out_data  <= data_in[win_idx*WIDTH +: WIDTH];
                out_sel   <= win_idx;
                out_valid <= 1'b1;
                // A locked channel keeps its slot, so the pointer only moves when free.
                if (state == ST_UNLOCKED) begin
                    ptr <= ptr_next;
                end
                if (lock[win_idx]) begin
                    state  <= ST_LOCKED;
                    locked <= 1'b1;
                end else begin
                    state  <= ST_UNLOCKED;
                    locked <= 1'b0;
                end
            end else begin
                // Nothing eligible: either idle, or the lock owner dropped its request.
                out_valid <= 1'b0;
                state     <= ST_UNLOCKED;
                locked    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bus_arb_mux.sv
module tb_bus_arb_mux;

    localparam int W    = 32;
    localparam int N    = 32;
    localparam int SELW = 5;

    logic             clock;
    logic             clear;
    logic [N-1:0]     req;
    logic [N-1:0]     lock;
    logic [N*W-1:0]   data_in;
    logic [N-1:0]     grant;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [SELW-1:0]  out_sel;
    logic             locked;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state, kept in plain integers.
    bit          m_valid;
    logic [W-1:0] m_data;
    int          m_sel;
    int          m_ptr;
    bit          m_locked;

    bus_arb_mux #(.WIDTH(W), .N(N)) dut (
        .clock     (clock),
        .clear     (clear),
        .req       (req),
        .lock      (lock),
        .data_in   (data_in),
        .grant     (grant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .locked    (locked)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First requester at or after the pointer, or only the lock owner while locked.
    function automatic int model_winner(input logic [N-1:0] r);
        if (m_locked) return r[m_sel] ? m_sel : -1;
        for (int i = 0; i < N; i++) begin
            if (r[(m_ptr + i) % N]) return (m_ptr + i) % N;
        end
        return -1;
    endfunction

    // One clock: check grant before the edge, advance the model, check outputs after.
    task automatic step();
        int w;
        bit ld_m;
        logic [N-1:0] exp_gnt;
        #1;
        ld_m = !m_valid || out_ready;
        w = (ld_m && !clear) ? model_winner(req) : -1;
        exp_gnt = '0;
        if (w >= 0) exp_gnt[w] = 1'b1;
        chk("grant", 64'(grant), 64'(exp_gnt));
        @(posedge clock);
        if (clear) begin
            m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0; m_locked = 0;
        end else if (ld_m) begin
            if (w >= 0) begin
                m_data  = data_in[w*W +: W];
                m_sel   = w;
                m_valid = 1;
                if (!m_locked) m_ptr = (w + 1) % N;
                m_locked = lock[w];
            end else begin
                m_valid  = 0;
                m_locked = 0;
            end
        end
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("locked", 64'(locked), 64'(m_locked));
        if (m_valid) begin
            chk("out_data", 64'(out_data), 64'(m_data));
            chk("out_sel", 64'(out_sel), 64'(m_sel));
        end
    endtask

    task automatic rand_data();
        for (int k = 0; k < N; k++) data_in[k*W +: W] = $urandom;
    endtask

    initial begin
        m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0; m_locked = 0;
        clear = 1'b1; req = '1; lock = '0; out_ready = 1'b1;
        rand_data();
        // Reset with every channel requesting: no grant, everything zero.
        step();
        chk("rst_out_data", 64'(out_data), 64'h0);
        chk("rst_out_sel", 64'(out_sel), 64'h0);
        clear = 1'b0;

        // Round-robin over channels 0..3.
        req = 32'hF;
        data_in[2*W +: W] = 32'h1234_5678;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_sel", 64'(out_sel), 64'(k % 4));
        end
        chk("rr_ch0_again", 64'(out_sel), 64'h0);

        // Back-pressure on a captured ch1 word.
        req = 32'h2;
        data_in[1*W +: W] = 32'hDEAD_BEEF;
        step();
        chk("bp_capture", 64'(out_data), 64'hDEAD_BEEF);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            data_in[1*W +: W] = $urandom;
            step();
            chk("bp_hold_data", 64'(out_data), 64'hDEAD_BEEF);
            chk("bp_hold_valid", 64'(out_valid), 64'h1);
        end
        out_ready = 1'b1;

        // Lock on ch2 with everyone requesting.
        req = '1;
        lock = 32'h4;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("lock_sel", 64'(out_sel), 64'h2);
            chk("lock_flag", 64'(locked), 64'h1);
        end
        lock = '0;
        step();
        chk("unlock_sel", 64'(out_sel), 64'h2);
        chk("unlock_flag", 64'(locked), 64'h0);
        step();
        chk("after_unlock_sel", 64'(out_sel), 64'h3);

        // Lock on ch0, then ch0 drops its request.
        req = 32'h1;
        lock = 32'h1;
        step();
        chk("lock0_flag", 64'(locked), 64'h1);
        req = 32'h0000_0220;
        step();
        chk("drop_valid", 64'(out_valid), 64'h0);
        chk("drop_locked", 64'(locked), 64'h0);
        lock = '0;
        step();
        chk("drop_next_sel", 64'(out_sel), 64'h5);

        // Wrap from channel 31, then idle.
        req = 32'h8000_0000;
        data_in[31*W +: W] = 32'hCAFE_F00D;
        step();
        chk("wrap_sel", 64'(out_sel), 64'd31);
        req = '0;
        step();
        chk("idle_valid", 64'(out_valid), 64'h0);
        chk("idle_hold_data", 64'(out_data), 64'hCAFE_F00D);
        req = 32'h4000_0001;
        step();
        chk("wrap_ptr_zero", 64'(out_sel), 64'h0);

        // Clear while a word is held under back-pressure.
        out_ready = 1'b0;
        clear = 1'b1;
        step();
        chk("midclr_data", 64'(out_data), 64'h0);
        clear = 1'b0;
        out_ready = 1'b1;

        // Random traffic against the model.
        for (int t = 0; t < 400; t++) begin
            req       = $urandom & $urandom;
            lock      = ($urandom_range(0, 3) == 0) ? ($urandom & $urandom) : '0;
            out_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 59) == 0);
            rand_data();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arb_mux.md
# bus_arb_mux

Parametrised, registered N-channel bus multiplexer for the CPU datapath bus; it generalises the fixed 32:1 select mux. Instead of a caller-supplied select code, channels raise requests. A round-robin arbiter with optional lock picks one, and its word is captured into an output register that holds under back-pressure. It sits between the register file / special-register sources (R0–R15, HI, LO, Zhigh, Zlow, PC, MDR, InPort, C) and the shared bus consumers.

## Interface
Parameters:
- WIDTH, 32, bits per channel word.
- N, 32, number of channels (2..64).
- SELW, $clog2(N), width of the channel index.

Ports (single clock; reset is synchronous and active-high):
- clock  in  1  rising-edge clock.
- clear  in  1  synchronous active-high reset.
- req  in  N  per-channel request; bit k belongs to channel k.
- lock  in  N  per-channel lock request, sampled only for the winning channel.
- data_in  in  N*WIDTH  flattened inputs; channel k is data_in[k*WIDTH +: WIDTH].
- grant  out  N  one-hot, combinational; bit k high means channel k's word is captured at this edge.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_data  out  WIDTH  registered selected word.
- out_sel  out  SELW  index of the channel that produced out_data.
- locked  out  1  arbiter is locked to out_sel.

## Operation
- Load enable: ld = !out_valid || out_ready.
- Winner selection uses pointer ptr.
  - Search order is ptr, ptr+1, ..., wrapping mod N.
  - The winner is the first channel with req high.
  - When locked, only channel out_sel is eligible.
- When ld=1 and a winner w exists:
  - grant = 1<<w.
  - out_data <= data_in[w].
  - out_sel <= w.
  - out_valid <= 1.
  - ptr <= (w+1) mod N, wrapping N-1 to 0.
- When ld=1 and there is no winner:
  - grant = 0.
  - out_valid <= 0.
  - out_data and out_sel keep their old values.
- When ld=0:
  - grant = 0.
  - out_data, out_sel and out_valid are held bit-stable.
- FSM states and transitions:
  - UNLOCKED → LOCKED on a capture from w with lock[w]=1.
  - LOCKED → LOCKED on a capture from out_sel with lock=1.
  - LOCKED → UNLOCKED on a capture from out_sel with lock=0.
  - LOCKED → UNLOCKED when ld=1 and req[out_sel]=0. In this case out_valid <= 0, and there is no same-cycle re-arbitration.
- ptr does not advance while LOCKED.
- Simultaneous requests: exactly one grant per cycle, never more than one grant bit set.
- Requests from channels with index ≥ N do not exist; there is no out-of-range behaviour.

## Timing
- Latency is one cycle: req asserted at edge t gives out_valid=1 with that data after edge t+1, provided ld=1.
- Throughput is one word per cycle while out_ready=1 and requests are present.
- clear values, applied at the edge regardless of state:
  - out_valid=0, out_data=0, out_sel=0.
  - ptr=0.
  - state UNLOCKED, locked=0.
  - grant=0 during the clear cycle.
- A clear in mid-transfer discards any held word. The consumer must not count a handshake in the clear cycle.
- grant is purely combinational from req, lock state, ptr, out_valid and out_ready.
- There is no path from data_in to any output except through the register.

## Structure
- Package bus_arb_pkg holds:
  - default WIDTH and N;
  - the state enum (ST_UNLOCKED, ST_LOCKED);
  - a function mapping a one-hot vector to its index.
- Sub-module rr_arbiter(N) holds the round-robin priority search. It takes req_masked and ptr and returns a one-hot winner plus a found flag.
- The top level owns the FSM, ptr, output register and data mux.

## Test plan
- Reset: drive clear with req=all ones → grant=0 during clear, then out_valid=0, out_data=0, out_sel=0, locked=0.
- Round-robin: N=4, req=4'b1111, out_ready=1 held → out_sel sequence 0,1,2,3,0 on consecutive cycles; each out_data equals data_in of that channel (e.g. 32'h1234_5678 on ch2).
- Back-pressure: capture ch1 (32'hDEAD_BEEF), then out_ready=0 for 3 cycles while data_in[1] changes → out_data stays 32'hDEAD_BEEF, grant=0, out_valid=1 throughout.
- Lock: ch2 captured with lock[2]=1, req=all ones → next two captures are ch2. Drop lock[2] → after that capture, locked=0 and the next grant goes to ch3.
- Lock release on drop: LOCKED on ch0, req[0] falls, ld=1 → out_valid=0, locked=0, then the next cycle grants the lowest requester from ptr.
- Wrap and idle: N=32, only req[31] high → out_sel=31 and ptr wraps to 0. Then with req=0 and out_ready=1 → out_valid=0 next cycle, while out_data still holds the ch31 word.
